grf: RTL and testbench
======================

# grf

General register file and write-back sink of the five-stage MIPS pipeline. It takes the write-back stage's write enable, address and data, and holds the 32×32-bit architectural registers. It serves two combinational read ports to the decode stage. A per-register pending-write scoreboard lets decode detect read-after-write hazards on results that have not yet been written back, and it raises a stall indication for those.

## Interface
Parameters:
- NUM_REGS, 32: number of architectural registers; register 0 is hard-wired to zero.
- CNT_W, 2: width of each per-register pending counter, so at most 2^CNT_W−1 writes can be outstanding per register.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high.
- pc_in, input, 32: PC of the instruction being written back; used only for the write log.
- reg_write_en_in, input, 1: write-back enable from the WB stage.
- reg_write_addr_in, input, 5: write-back destination.
- reg_write_data_in, input, 32: write-back data.
- reserve_en_in, input, 1: decode issues an instruction that will write reserve_addr_in at WB.
- reserve_addr_in, input, 5: destination being reserved.
- rs_addr_in, input, 5: read port A address.
- rt_addr_in, input, 5: read port B address.
- rs_data_out, output, 32: read port A data.
- rt_data_out, output, 32: read port B data.
- rs_busy_out, output, 1: rs has an outstanding write, so decode must stall or forward.
- rt_busy_out, output, 1: rt has an outstanding write.
- overflow_out, output, 1: sticky flag; a reservation was attempted on a saturated counter.

## Operation
- Register write: on a clock edge with reg_write_en_in=1 and reg_write_addr_in≠0, reg[addr] ← data.
  - Writes to register 0 are discarded, and no log line is produced for them.
- Write log (simulation only, every non-zero write): `$display("@%h: $%d <= %h", pc_in, addr, data)`.
- Reads: combinational.
  - Address 0 always returns 0.
  - Otherwise the port returns reg[addr], subject to the bypass rule in Configuration.
- Scoreboard: one CNT_W-bit counter per register.
  - A reservation (reserve_en_in, address≠0) adds 1.
  - An enabled write to a non-zero address subtracts 1.
  - A reservation and a write to the same register in the same cycle leave the counter unchanged.
- Write with counter=0: the data write still happens; the counter stays 0 and does not wrap.
- Reservation with counter at maximum (2^CNT_W−1): the counter holds, and overflow_out is set and stays set until reset.
- Busy outputs:
  - busy = (counter[addr]≠0) for addr≠0.
  - busy is always 0 for addr 0.
  - The bypass exception is given in Configuration.
- Reservations are made only for instructions guaranteed to reach WB; the block does not support cancelling a reservation.

## Timing
- Reset (synchronous): every register is cleared to 0, every counter to 0, and overflow_out to 0.
  - Combinational outputs then follow: rs/rt data 0, busy 0.
- A reset asserted in the same cycle as a write or reservation wins; that write or reservation is lost.
- Write latency: data written at edge N is visible on the read ports from edge N onward, i.e. in cycle N+1 without bypass.
- Scoreboard latency:
  - A reservation at edge N raises busy in cycle N+1.
  - A write at edge N clears busy in cycle N+1 if the counter reaches 0.
- Simultaneous write to register X and read of X in the same cycle: the result depends on GRF_BYPASS_EN.

## Configuration
- GRF_BYPASS_EN defined (internal forwarding):
  - If reg_write_en_in=1, reg_write_addr_in≠0 and it equals a read address, that port returns reg_write_data_in in the same cycle.
  - The port's busy is 0 when counter[addr]=1 in that same cycle, because the last pending write is arriving now.
- GRF_BYPASS_EN undefined:
  - Reads return the stored value, which is stale in the write cycle.
  - Busy is taken from the registered counter only, so decode loses one extra stall cycle per dependence.

## Structure
- Shared package `mips_pkg`: NUM_REGS, REG_ADDR_W=5, DATA_W=32, CNT_W, and the zero-register constant.
- One sub-module, `grf_scoreboard`:
  - Contains the counter array, the saturation/underflow logic and overflow_out.
  - Exports the per-register pending flags plus a "last pending" (count==1) vector for the bypass busy rule.
- The top level holds the register array, the read multiplexing, the bypass logic and the write log.

## Test plan
- Reset, then read rs=5, rt=0: both data 0, both busy 0, overflow_out 0.
- Write 0xDEADBEEF to $8 at pc 0x3000: the log prints "@00003000: $ 8 <= deadbeef", and a read of $8 returns 0xDEADBEEF in the following cycle. A write of 0x1234 to $0 reads back as 0 and prints no log line.
- Reserve $9, then two cycles later write $9=0x55:
  - rs_busy_out=1 for rs=9 from the cycle after the reserve.
  - Busy clears in the cycle after the write, or in the write cycle itself with bypass.
- Same-cycle write $10=0xA5A5A5A5 and read rs=10:
  - With GRF_BYPASS_EN: rs_data_out=0xA5A5A5A5 in that cycle.
  - Without: the old value in that cycle.
- Reserve $3 four times back-to-back with CNT_W=2: the counter stops at 3 and overflow_out is set and sticky. Three writes to $3 then clear busy.
- Simultaneous reserve and write on $4 with counter=1: the counter stays at 1 and busy stays 1. A write to $6 with counter=0 stores the data and leaves the counter at 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: register file geometry and scoreboard width.
package mips_pkg;
    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int CNT_W      = 2;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;
endpackage

// File: rtl/grf_scoreboard.sv
// Per-register pending-write counters for the GRF; saturates on over-reservation
// (sticky overflow) and never wraps below zero on an unreserved write.
module grf_scoreboard
    import mips_pkg::*;
#(
    parameter int NUM_REGS = mips_pkg::NUM_REGS,
    parameter int CNT_W    = mips_pkg::CNT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reserve_en,
    input  logic [REG_ADDR_W-1:0] reserve_addr,
    input  logic                  write_en,
    input  logic [REG_ADDR_W-1:0] write_addr,
    output logic [NUM_REGS-1:0]   pending,
    output logic [NUM_REGS-1:0]   last_pending,
    output logic                  overflow
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt [NUM_REGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
        end else begin
            // Register 0 is never tracked; a same-cycle reserve and write cancel out.
            for (int i = 1; i < NUM_REGS; i++) begin
                if (reserve_en && reserve_addr == REG_ADDR_W'(i) &&
                    !(write_en && write_addr == REG_ADDR_W'(i))) begin
                    if (cnt[i] == CNT_MAX) overflow <= 1'b1;
                    else                   cnt[i] <= cnt[i] + CNT_ONE;
                end else if (write_en && write_addr == REG_ADDR_W'(i) &&
                             !(reserve_en && reserve_addr == REG_ADDR_W'(i))) begin
                    if (cnt[i] != '0) cnt[i] <= cnt[i] - CNT_ONE;
                end
            end
        end
    end

    always_comb begin
        pending      = '0;
        last_pending = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            pending[i]      = (cnt[i] != '0);
            last_pending[i] = (cnt[i] == CNT_ONE);
        end
    end
endmodule

// File: rtl/grf.sv
// MIPS general register file with two combinational read ports and a pending-write
// scoreboard. Define GRF_BYPASS_EN to forward same-cycle write-back data to the reads.
module grf
    import mips_pkg::*;
#(
    parameter int NUM_REGS = mips_pkg::NUM_REGS,
    parameter int CNT_W    = mips_pkg::CNT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           pc_in,
    input  logic                  reg_write_en_in,
    input  logic [REG_ADDR_W-1:0] reg_write_addr_in,
    input  logic [DATA_W-1:0]     reg_write_data_in,
    input  logic                  reserve_en_in,
    input  logic [REG_ADDR_W-1:0] reserve_addr_in,
    input  logic [REG_ADDR_W-1:0] rs_addr_in,
    input  logic [REG_ADDR_W-1:0] rt_addr_in,
    output logic [DATA_W-1:0]     rs_data_out,
    output logic [DATA_W-1:0]     rt_data_out,
    output logic                  rs_busy_out,
    output logic                  rt_busy_out,
    output logic                  overflow_out
);
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] last_pending;
    logic                wr_valid;

    assign wr_valid = reg_write_en_in && (reg_write_addr_in != ZERO_REG);

    grf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .CNT_W    (CNT_W)
    ) u_scoreboard (
        .clk          (clk),
        .reset        (reset),
        .reserve_en   (reserve_en_in),
        .reserve_addr (reserve_addr_in),
        .write_en     (reg_write_en_in),
        .write_addr   (reg_write_addr_in),
        .pending      (pending),
        .last_pending (last_pending),
        .overflow     (overflow_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_valid) begin
            regs[reg_write_addr_in] <= reg_write_data_in;
`ifndef SYNTHESIS
            $display("@%h: $%d <= %h", pc_in, reg_write_addr_in, reg_write_data_in);
`endif
        end
    end

`ifdef GRF_BYPASS_EN
    logic rs_hit, rt_hit;
    assign rs_hit = wr_valid && (reg_write_addr_in == rs_addr_in);
    assign rt_hit = wr_valid && (reg_write_addr_in == rt_addr_in);

    // The arriving write retires the last pending reservation, so it no longer blocks.
    always_comb begin
        rs_data_out = '0;
        rt_data_out = '0;
        rs_busy_out = 1'b0;
        rt_busy_out = 1'b0;
        if (rs_addr_in != ZERO_REG) begin
            rs_data_out = rs_hit ? reg_write_data_in : regs[rs_addr_in];
            rs_busy_out = pending[rs_addr_in] && !(rs_hit && last_pending[rs_addr_in]);
        end
        if (rt_addr_in != ZERO_REG) begin
            rt_data_out = rt_hit ? reg_write_data_in : regs[rt_addr_in];
            rt_busy_out = pending[rt_addr_in] && !(rt_hit && last_pending[rt_addr_in]);
        end
    end
`else
    logic unused_last_pending;
    assign unused_last_pending = ^last_pending;

    always_comb begin
        rs_data_out = '0;
        rt_data_out = '0;
        rs_busy_out = 1'b0;
        rt_busy_out = 1'b0;
        if (rs_addr_in != ZERO_REG) begin
            rs_data_out = regs[rs_addr_in];
            rs_busy_out = pending[rs_addr_in];
        end
        if (rt_addr_in != ZERO_REG) begin
            rt_data_out = regs[rt_addr_in];
            rt_busy_out = pending[rt_addr_in];
        end
    end
`endif
endmodule

// File: tb/tb_grf.sv
// Directed self-checking bench for grf; expectations follow GRF_BYPASS_EN when defined.
module tb_grf;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in;
    logic        reg_write_en_in;
    logic [4:0]  reg_write_addr_in;
    logic [31:0] reg_write_data_in;
    logic        reserve_en_in;
    logic [4:0]  reserve_addr_in;
    logic [4:0]  rs_addr_in;
    logic [4:0]  rt_addr_in;
    logic [31:0] rs_data_out;
    logic [31:0] rt_data_out;
    logic        rs_busy_out;
    logic        rt_busy_out;
    logic        overflow_out;

    int errors = 0;
    int checks = 0;

`ifdef GRF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    always #5 clk = ~clk;

    grf dut (
        .clk               (clk),
        .reset             (reset),
        .pc_in             (pc_in),
        .reg_write_en_in   (reg_write_en_in),
        .reg_write_addr_in (reg_write_addr_in),
        .reg_write_data_in (reg_write_data_in),
        .reserve_en_in     (reserve_en_in),
        .reserve_addr_in   (reserve_addr_in),
        .rs_addr_in        (rs_addr_in),
        .rt_addr_in        (rt_addr_in),
        .rs_data_out       (rs_data_out),
        .rt_data_out       (rt_data_out),
        .rs_busy_out       (rs_busy_out),
        .rt_busy_out       (rt_busy_out),
        .overflow_out      (overflow_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are then sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; pc_in = '0;
        reg_write_en_in = 1'b0; reg_write_addr_in = '0; reg_write_data_in = '0;
        reserve_en_in = 1'b0; reserve_addr_in = '0;
        rs_addr_in = 5'd5; rt_addr_in = 5'd0;
        tick(); tick();
        reset = 1'b0;
        #1;
        check("rst_rs_data", rs_data_out, 32'h0);
        check("rst_rt_data", rt_data_out, 32'h0);
        check("rst_rs_busy", {31'b0, rs_busy_out}, 32'h0);
        check("rst_rt_busy", {31'b0, rt_busy_out}, 32'h0);
        check("rst_overflow", {31'b0, overflow_out}, 32'h0);

        // $8 <= DEADBEEF
        pc_in = 32'h3000; reg_write_en_in = 1'b1; reg_write_addr_in = 5'd8;
        reg_write_data_in = 32'hDEADBEEF; rs_addr_in = 5'd8; rt_addr_in = 5'd8;
        #1;
        check("w8_same_cycle", rs_data_out, BYP ? 32'hDEADBEEF : 32'h0);
        tick();
        reg_write_en_in = 1'b0;
        #1;
        check("w8_rs_read", rs_data_out, 32'hDEADBEEF);
        check("w8_rt_read", rt_data_out, 32'hDEADBEEF);

        // $0 write is discarded
        reg_write_en_in = 1'b1; reg_write_addr_in = 5'd0; reg_write_data_in = 32'h1234;
        rs_addr_in = 5'd0;
        #1;
        check("w0_same_cycle", rs_data_out, 32'h0);
        tick();
        reg_write_en_in = 1'b0;
        #1;
        check("w0_read", rs_data_out, 32'h0);
        check("w0_busy", {31'b0, rs_busy_out}, 32'h0);

        // Reserve $9, write it two cycles later
        reserve_en_in = 1'b1; reserve_addr_in = 5'd9; rs_addr_in = 5'd9;
        #1;
        check("r9_before_edge", {31'b0, rs_busy_out}, 32'h0);
        tick();
        reserve_en_in = 1'b0;
        #1;
        check("r9_busy_n1", {31'b0, rs_busy_out}, 32'h1);
        tick();
        check("r9_busy_n2", {31'b0, rs_busy_out}, 32'h1);
        reg_write_en_in = 1'b1; reg_write_addr_in = 5'd9; reg_write_data_in = 32'h55;
        #1;
        check("w9_busy_write_cycle", {31'b0, rs_busy_out}, BYP ? 32'h0 : 32'h1);
        check("w9_data_write_cycle", rs_data_out, BYP ? 32'h55 : 32'h0);
        tick();
        reg_write_en_in = 1'b0;
        #1;
        check("w9_busy_after", {31'b0, rs_busy_out}, 32'h0);
        check("w9_data_after", rs_data_out, 32'h55);

        // Same-cycle write and read of $10
        reg_write_en_in = 1'b1; reg_write_addr_in = 5'd10; reg_write_data_in = 32'h11111111;
        tick();
        reg_write_data_in = 32'hA5A5A5A5; rs_addr_in = 5'd10;
        #1;
        check("w10_same_cycle", rs_data_out, BYP ? 32'hA5A5A5A5 : 32'h11111111);
        tick();
        reg_write_en_in = 1'b0;
        #1;
        check("w10_after", rs_data_out, 32'hA5A5A5A5);

        // Saturate $3 with four reservations
        reserve_en_in = 1'b1; reserve_addr_in = 5'd3; rt_addr_in = 5'd3;
        tick(); tick(); tick();
        check("r3_no_overflow_at_3", {31'b0, overflow_out}, 32'h0);
        check("r3_busy", {31'b0, rt_busy_out}, 32'h1);
        tick();
        reserve_en_in = 1'b0;
        #1;
        check("r3_overflow_set", {31'b0, overflow_out}, 32'h1);
        reg_write_en_in = 1'b1; reg_write_addr_in = 5'd3; reg_write_data_in = 32'h7;
        tick();
        check("w3_busy_cnt2", {31'b0, rt_busy_out}, 32'h1);
        tick();
        check("w3_busy_cnt1", {31'b0, rt_busy_out}, BYP ? 32'h0 : 32'h1);
        tick();
        reg_write_en_in = 1'b0;
        #1;
        check("w3_busy_cleared", {31'b0, rt_busy_out}, 32'h0);
        check("r3_overflow_sticky", {31'b0, overflow_out}, 32'h1);
        check("w3_data", rt_data_out, 32'h7);

        // $4: simultaneous reserve and write at counter=1
        reserve_en_in = 1'b1; reserve_addr_in = 5'd4; rt_addr_in = 5'd4;
        tick();
        reg_write_en_in = 1'b1; reg_write_addr_in = 5'd4; reg_write_data_in = 32'h44;
        tick();
        reserve_en_in = 1'b0; reg_write_en_in = 1'b0;
        #1;
        check("rw4_busy_held", {31'b0, rt_busy_out}, 32'h1);
        check("rw4_data", rt_data_out, 32'h44);
        reg_write_en_in = 1'b1; reg_write_data_in = 32'h45;
        tick();
        reg_write_en_in = 1'b0;
        #1;
        check("w4_busy_cleared", {31'b0, rt_busy_out}, 32'h0);

        // $6: write with counter=0 must not wrap
        reg_write_en_in = 1'b1; reg_write_addr_in = 5'd6; reg_write_data_in = 32'h66;
        rt_addr_in = 5'd6;
        tick();
        reg_write_en_in = 1'b0;
        #1;
        check("w6_data", rt_data_out, 32'h66);
        check("w6_busy", {31'b0, rt_busy_out}, 32'h0);
        reserve_en_in = 1'b1; reserve_addr_in = 5'd6;
        tick();
        reserve_en_in = 1'b0;
        #1;
        check("r6_busy", {31'b0, rt_busy_out}, 32'h1);
        reg_write_en_in = 1'b1; reg_write_data_in = 32'h67;
        tick();
        reg_write_en_in = 1'b0;
        #1;
        check("w6_no_wrap", {31'b0, rt_busy_out}, 32'h0);

        // Reset beats a concurrent write and reservation
        reset = 1'b1; reg_write_en_in = 1'b1; reg_write_addr_in = 5'd8;
        reg_write_data_in = 32'hFFFF; reserve_en_in = 1'b1; reserve_addr_in = 5'd3;
        rs_addr_in = 5'd8; rt_addr_in = 5'd3;
        tick();
        reset = 1'b0; reg_write_en_in = 1'b0; reserve_en_in = 1'b0;
        #1;
        check("rst2_rs_data", rs_data_out, 32'h0);
        check("rst2_rt_busy", {31'b0, rt_busy_out}, 32'h0);
        check("rst2_overflow", {31'b0, overflow_out}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
